// File: rtl/md_arb.sv
// md_arb: round-robin issue arbiter in front of a shared multiply/divide unit.
// Define MD_ARB_PERF_EN to add the perf_stall_cnt stall counter output.
module md_arb #(
  parameter int NUM_REQ = 2,
  parameter int UOP_W   = 96,
  parameter int MAX_MUL = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_is_div,
  input  logic [NUM_REQ-1:0][UOP_W-1:0]   req_uop,
  output logic                            fu_valid,
  input  logic                            fu_ready,
  output logic [UOP_W-1:0]                fu_uop,
  output logic                            fu_is_div,
  input  logic                            mul_done,
  input  logic                            div_done,
  output logic                            busy
`ifdef MD_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(MAX_MUL + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_MUL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REQ - 1);

  logic               fu_valid_q, fu_valid_d;
  logic [UOP_W-1:0]   fu_uop_q, fu_uop_d;
  logic               fu_is_div_q, fu_is_div_d;
  logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic               div_busy_q, div_busy_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               load_en;
  logic               mul_dec;
  logic               mul_room;
  logic [NUM_REQ-1:0] eligible;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_is_div;

  // A multiply retiring this cycle frees its slot immediately, so a waiting
  // multiply can be granted in the same cycle as the mul_done pulse.
  always_comb begin
    load_en  = (!fu_valid_q || fu_ready) && !flush && rst_n;
    mul_dec  = mul_done && (mul_cnt_q != '0);
    mul_room = (mul_cnt_q < MAX_CNT) || mul_dec;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (req_is_div[i] ? !div_busy_q : mul_room);
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant_oh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_any && load_en && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) begin
      grant_oh[grant_idx] = 1'b1;
    end
    grant_is_div = req_is_div[grant_idx];
  end

  always_comb begin
    fu_valid_d  = fu_valid_q;
    fu_uop_d    = fu_uop_q;
    fu_is_div_d = fu_is_div_q;
    mul_cnt_d   = mul_cnt_q;
    div_busy_d  = div_busy_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      fu_valid_d = 1'b0;
      mul_cnt_d  = '0;
      div_busy_d = 1'b0;
      rr_ptr_d   = '0;
    end else begin
      if (load_en) begin
        fu_valid_d = grant_any;
        if (grant_any) begin
          fu_uop_d    = req_uop[grant_idx];
          fu_is_div_d = grant_is_div;
          rr_ptr_d    = (grant_idx == LAST_PTR) ? '0 : grant_idx + PTR_W'(1);
        end
      end
      // Occupancy is counted at grant time, so the held op is already included.
      if (grant_any && !grant_is_div && !mul_dec) begin
        mul_cnt_d = mul_cnt_q + CNT_W'(1);
      end else if (!(grant_any && !grant_is_div) && mul_dec) begin
        mul_cnt_d = mul_cnt_q - CNT_W'(1);
      end
      if (grant_any && grant_is_div) begin
        div_busy_d = 1'b1;
      end else if (div_done) begin
        div_busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_valid_q  <= 1'b0;
      fu_uop_q    <= '0;
      fu_is_div_q <= 1'b0;
      mul_cnt_q   <= '0;
      div_busy_q  <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      fu_valid_q  <= fu_valid_d;
      fu_uop_q    <= fu_uop_d;
      fu_is_div_q <= fu_is_div_d;
      mul_cnt_q   <= mul_cnt_d;
      div_busy_q  <= div_busy_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef MD_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    if ((|req_valid) && !grant_any) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
`endif

  assign req_ready = grant_oh;
  assign fu_valid  = fu_valid_q;
  assign fu_uop    = fu_uop_q;
  assign fu_is_div = fu_is_div_q;
  assign busy      = fu_valid_q || div_busy_q || (mul_cnt_q != '0);

endmodule
